// File: rtl/int_controller.sv
// rtl/int_controller.sv - single-level edge-triggered interrupt controller
// Fixed-priority selection (index 0 highest) feeding a REQ/SERVICE handshake with the CPU.
module int_controller #(
  parameter int          N_IRQ      = 8,
  parameter logic [9:0]  VEC_BASE   = 10'h3C0,
  parameter int          VEC_STRIDE = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_IRQ-1:0] irq,
  input  logic             gie,
  input  logic             we_mask,
  input  logic [N_IRQ-1:0] mask_in,
  input  logic             int_ack,
  input  logic             iret,
  output logic             int_req,
  output logic [7:0]       int_vec,
  output logic [9:0]       int_addr,
  output logic [N_IRQ-1:0] pending,
  output logic             in_service,
  output logic             spur_iret
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    REQ     = 2'd1,
    SERVICE = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nx;
  logic [N_IRQ-1:0] s1;
  logic [N_IRQ-1:0] s2;
  logic [N_IRQ-1:0] s3;
  logic [N_IRQ-1:0] mask;
  logic [N_IRQ-1:0] rise;
  logic [N_IRQ-1:0] eligible;
  logic [N_IRQ-1:0] clr;
  logic [7:0]       elig8;
  logic [2:0]       sel;
  logic [2:0]       idx_q;
  logic             ack_hit;
  logic             active;

  // s1/s2 resynchronise the async lines; s3 only exists to detect the rising edge.
  assign rise     = s2 & ~s3;
  assign eligible = pending & mask & {N_IRQ{gie}};
  assign elig8    = 8'(eligible);
  assign ack_hit  = (state == REQ) && int_ack;

  always_comb begin
    sel = 3'd0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (eligible[i]) sel = 3'(i);
    end
  end

  always_comb begin
    clr = '0;
    for (int i = 0; i < N_IRQ; i++) begin
      clr[i] = ack_hit && (idx_q == 3'(i));
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (|eligible) state_nx = REQ;
      // The latched index is kept even if a higher-priority source arrives meanwhile.
      REQ: begin
        if (int_ack)             state_nx = SERVICE;
        else if (!elig8[idx_q])  state_nx = IDLE;
      end
      SERVICE: if (iret) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      s1        <= '0;
      s2        <= '0;
      s3        <= '0;
      pending   <= '0;
      mask      <= '0;
      idx_q     <= 3'd0;
      state     <= IDLE;
      spur_iret <= 1'b0;
    end else begin
      s1        <= irq;
      s2        <= s1;
      s3        <= s2;
      // A new edge in the same cycle as the ack-clear keeps the bit pending.
      pending   <= (pending & ~clr) | rise;
      if (we_mask) mask <= mask_in;
      state     <= state_nx;
      if (state == IDLE && state_nx == REQ) idx_q <= sel;
      spur_iret <= iret && (state != SERVICE);
    end
  end

  assign active     = (state == REQ) || (state == SERVICE);
  assign int_req    = (state == REQ);
  assign in_service = (state == SERVICE);
  assign int_vec    = active ? {5'b10000, idx_q} : 8'h00;
  assign int_addr   = active ? (VEC_BASE + 10'(idx_q) * 10'(VEC_STRIDE)) : 10'h000;

endmodule

// File: tb/tb_int_controller.sv
// tb/tb_int_controller.sv - directed scoreboard bench for int_controller
module tb_int_controller;

  logic       clk;
  logic       reset;
  logic [7:0] irq;
  logic       gie;
  logic       we_mask;
  logic [7:0] mask_in;
  logic       int_ack;
  logic       iret;
  logic       int_req;
  logic [7:0] int_vec;
  logic [9:0] int_addr;
  logic [7:0] pending;
  logic       in_service;
  logic       spur_iret;

  int n_assert = 0;
  int n_fail   = 0;

  string       tag_q[$];
  logic [31:0] exp_q[$];

  int_controller #(.N_IRQ(8), .VEC_BASE(10'h3C0), .VEC_STRIDE(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .irq       (irq),
    .gie       (gie),
    .we_mask   (we_mask),
    .mask_in   (mask_in),
    .int_ack   (int_ack),
    .iret      (iret),
    .int_req   (int_req),
    .int_vec   (int_vec),
    .int_addr  (int_addr),
    .pending   (pending),
    .in_service(in_service),
    .spur_iret (spur_iret)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_val(input string t, input logic [31:0] v);
    tag_q.push_back(t);
    exp_q.push_back(v);
  endtask

  task automatic check_val(input logic [31:0] obs);
    string       t;
    logic [31:0] e;
    n_assert++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL scoreboard_empty: observed %0h required an expectation", obs);
    end else begin
      t = tag_q.pop_front();
      e = exp_q.pop_front();
      assert (obs === e) else begin
        n_fail++;
        $error("FAIL %s: observed %0h expected %0h", t, obs, e);
      end
    end
  endtask

  // Wait (bounded) for int_req, then compare it so a timeout counts as a failure.
  task automatic wait_req(input string t, input int budget);
    for (int k = 0; k < budget; k++) begin
      if (int_req) break;
      @(negedge clk);
    end
    expect_val(t, 32'd1);
    check_val(32'(int_req));
  endtask

  task automatic pulse_ack();
    int_ack = 1'b1;
    tick(1);
    int_ack = 1'b0;
  endtask

  task automatic pulse_iret();
    iret = 1'b1;
    tick(1);
    iret = 1'b0;
  endtask

  initial begin
    reset = 1'b1; irq = 8'h00; gie = 1'b0; we_mask = 1'b0; mask_in = 8'h00;
    int_ack = 1'b0; iret = 1'b0;
    tick(3);
    expect_val("rst_req", 0);       check_val(32'(int_req));
    expect_val("rst_vec", 0);       check_val(32'(int_vec));
    expect_val("rst_addr", 0);      check_val(32'(int_addr));
    expect_val("rst_pend", 0);      check_val(32'(pending));
    expect_val("rst_svc", 0);       check_val(32'(in_service));
    expect_val("rst_spur", 0);      check_val(32'(spur_iret));
    reset = 1'b0;
    gie = 1'b1; we_mask = 1'b1; mask_in = 8'hFF;
    tick(1);
    we_mask = 1'b0;
    tick(1);

    // 1: exact sync latency on irq[3]
    irq = 8'h08;
    expect_val("t1_pend_e2", 8'h00);
    tick(2);
    check_val(32'(pending));
    expect_val("t1_pend_e3", 8'h08);
    expect_val("t1_req_e3", 0);
    tick(1);
    check_val(32'(pending));
    check_val(32'(int_req));
    expect_val("t1_req_e4", 1);
    expect_val("t1_vec", 8'h83);
    expect_val("t1_addr", 10'h3CC);
    tick(1);
    check_val(32'(int_req));
    check_val(32'(int_vec));
    check_val(32'(int_addr));
    expect_val("t1_svc", 1);
    expect_val("t1_svc_req", 0);
    expect_val("t1_svc_pend", 8'h00);
    expect_val("t1_svc_vec", 8'h83);
    pulse_ack();
    check_val(32'(in_service));
    check_val(32'(int_req));
    check_val(32'(pending));
    check_val(32'(int_vec));
    irq = 8'h00;
    expect_val("t1_iret_vec", 8'h00);
    expect_val("t1_iret_svc", 0);
    pulse_iret();
    check_val(32'(int_vec));
    check_val(32'(in_service));
    tick(2);

    // 2: simultaneous edges, priority then the remaining source
    irq = 8'h22;
    wait_req("t2_req1", 10);
    expect_val("t2_vec1", 8'h81);
    expect_val("t2_addr1", 10'h3C4);
    check_val(32'(int_vec));
    check_val(32'(int_addr));
    expect_val("t2_pend", 8'h20);
    pulse_ack();
    check_val(32'(pending));
    expect_val("t2_gap_req", 0);
    expect_val("t2_gap_vec", 8'h00);
    pulse_iret();
    check_val(32'(int_req));
    check_val(32'(int_vec));
    expect_val("t2_req2", 1);
    expect_val("t2_vec2", 8'h85);
    expect_val("t2_addr2", 10'h3D4);
    tick(1);
    check_val(32'(int_req));
    check_val(32'(int_vec));
    check_val(32'(int_addr));
    pulse_ack();
    irq = 8'h00;
    pulse_iret();
    tick(2);

    // 3: mask withdrawal in REQ, then re-raise on unmask
    irq = 8'h04;
    wait_req("t3_req", 10);
    expect_val("t3_vec", 8'h82);
    check_val(32'(int_vec));
    we_mask = 1'b1; mask_in = 8'hFB;
    expect_val("t3_req_oldmask", 1);
    tick(1);
    we_mask = 1'b0;
    check_val(32'(int_req));
    expect_val("t3_req_drop", 0);
    expect_val("t3_pend_kept", 8'h04);
    tick(1);
    check_val(32'(int_req));
    check_val(32'(pending));
    we_mask = 1'b1; mask_in = 8'hFF;
    tick(1);
    we_mask = 1'b0;
    expect_val("t3_rereq", 1);
    expect_val("t3_revec", 8'h82);
    tick(1);
    check_val(32'(int_req));
    check_val(32'(int_vec));
    pulse_ack();
    irq = 8'h00;
    pulse_iret();
    tick(2);

    // 4: new edge on the serviced source while in SERVICE
    irq = 8'h01;
    wait_req("t4_req", 10);
    pulse_ack();
    irq = 8'h00;
    tick(2);
    irq = 8'h01;
    expect_val("t4_svc_req", 0);
    expect_val("t4_svc", 1);
    expect_val("t4_svc_pend", 8'h01);
    tick(5);
    check_val(32'(int_req));
    check_val(32'(in_service));
    check_val(32'(pending));
    expect_val("t4_gap_req", 0);
    expect_val("t4_gap_vec", 8'h00);
    pulse_iret();
    check_val(32'(int_req));
    check_val(32'(int_vec));
    expect_val("t4_rereq", 1);
    expect_val("t4_revec", 8'h80);
    tick(1);
    check_val(32'(int_req));
    check_val(32'(int_vec));
    pulse_ack();
    irq = 8'h00;
    pulse_iret();
    tick(2);

    // 5: spurious iret and stray ack in IDLE
    expect_val("t5_spur_hi", 1);
    expect_val("t5_spur_svc", 0);
    pulse_iret();
    check_val(32'(spur_iret));
    check_val(32'(in_service));
    expect_val("t5_spur_lo", 0);
    tick(1);
    check_val(32'(spur_iret));
    expect_val("t5_ack_req", 0);
    expect_val("t5_ack_svc", 0);
    expect_val("t5_ack_vec", 8'h00);
    pulse_ack();
    check_val(32'(int_req));
    check_val(32'(in_service));
    check_val(32'(int_vec));
    tick(1);

    // 6: reset while in SERVICE with other sources pending
    irq = 8'h01;
    wait_req("t6_req", 10);
    pulse_ack();
    irq = 8'h15;
    expect_val("t6_pend", 8'h14);
    tick(4);
    check_val(32'(pending));
    reset = 1'b1; irq = 8'h00;
    expect_val("t6_rst_req", 0);
    expect_val("t6_rst_vec", 0);
    expect_val("t6_rst_addr", 0);
    expect_val("t6_rst_pend", 0);
    expect_val("t6_rst_svc", 0);
    expect_val("t6_rst_spur", 0);
    tick(1);
    check_val(32'(int_req));
    check_val(32'(int_vec));
    check_val(32'(int_addr));
    check_val(32'(pending));
    check_val(32'(in_service));
    check_val(32'(spur_iret));
    reset = 1'b0;
    we_mask = 1'b1; mask_in = 8'hFF;
    tick(1);
    we_mask = 1'b0;
    expect_val("t6_quiet_req", 0);
    expect_val("t6_quiet_pend", 0);
    tick(6);
    check_val(32'(int_req));
    check_val(32'(pending));
    irq = 8'h10;
    wait_req("t6_new_req", 10);
    expect_val("t6_new_vec", 8'h84);
    check_val(32'(int_vec));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
